ps2_scancode_ctrl: RTL and testbench
====================================

PS2_SCANCODE_CTRL -- requirements
Module: ps2_scancode_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2, 2..16).
REQ-002 Parameter PREFIX_TIMEOUT, default 50_000, meaning clk cycles (2 ms at 25 MHz) a pending prefix survives without a following byte.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle pulse: rx_data holds a parity/framing-checked PS/2 byte.
REQ-006 rx_data  input  8  received scan-code byte.
REQ-007 evt_pop  input  1  host consumes head event; ignored when FIFO empty.
REQ-008 irq_en  input  1  interrupt enable.
REQ-009 err_clear  input  1  clears sticky overflow and proto_err.
REQ-010 evt_valid  output  1  FIFO non-empty.
REQ-011 evt_code  output  8  head event scan code (first-word fall-through).
REQ-012 evt_ext  output  1  head event carried 0xE0 prefix.
REQ-013 evt_break  output  1  head event is key release (0xF0 prefix).
REQ-014 evt_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-015 irq  output  1  level: evt_valid AND irq_en.
REQ-016 overflow  output  1  sticky: an event was dropped on a full FIFO.
REQ-017 proto_err  output  1  sticky: illegal prefix sequence, prefix timeout, or keyboard error code.

Function
REQ-018 Prefix FSM states SHALL be IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0,0xF0 seen); acts only on cycles with rx_valid=1.
REQ-019 IDLE: 0xE0->EXT; 0xF0->BRK; 0x00 or 0xFF->set proto_err, stay IDLE, no event; any other byte->push {code,ext=0,brk=0}.
REQ-020 EXT: 0xF0->EXT_BRK; 0xE0->stay EXT; 0x00/0xFF->proto_err, IDLE; other->push {code,ext=1,brk=0}, IDLE.
REQ-021 BRK: 0xF0->stay BRK; 0xE0->proto_err, EXT; 0x00/0xFF->proto_err, IDLE; other->push {code,ext=0,brk=1}, IDLE.
REQ-022 EXT_BRK: 0xE0/0xF0/0x00/0xFF->proto_err, IDLE, no event; other->push {code,ext=1,brk=1}, IDLE.
REQ-023 Push SHALL occur in the cycle after the rx_valid that completes the event; event visible on evt_* one cycle after push (latency 2 clk from rx_valid to evt_valid on empty FIFO).
REQ-024 Timeout counter SHALL clear on every rx_valid and while IDLE, otherwise increment; at PREFIX_TIMEOUT-1 the FSM returns to IDLE and proto_err sets.
REQ-025 FIFO pop SHALL occur when evt_pop=1 and count>0; evt_* then show the next entry the following cycle.
REQ-026 Push with count=FIFO_DEPTH and no pop in the same cycle SHALL drop the new event and set overflow; the existing entries SHALL remain intact.
REQ-027 Simultaneous push and pop SHALL both succeed, including at full and at count=1 (count unchanged).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-029 err_clear coincident with a new error SHALL leave the flag set (set wins).
REQ-030 evt_code/evt_ext/evt_break SHALL read 0 when FIFO empty.

Reset
REQ-031 reset SHALL force FSM=IDLE, timeout counter=0, FIFO pointers and count=0, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, irq=0, overflow=0, proto_err=0.
REQ-032 reset mid-sequence SHALL discard any pending prefix and all queued events; rx_valid during reset SHALL be ignored.

Structure
REQ-033 Shared package ps2_pkg SHALL hold scan-code constants (E0, F0, 00, FF), FSM state encodings, and the 10-bit event field layout.
REQ-034 FIFO SHALL be a separate sub-module ps2_event_fifo (parameterised width/depth, FWFT); FSM and timeout stay in the top.

Verification
REQ-035 Bytes 0x1C; 0xF0,0x1C -> two events {1C,ext0,brk0},{1C,ext0,brk1}; irq high with irq_en=1, low after two pops.
REQ-036 Bytes 0xE0,0x75; 0xE0,0xF0,0x75 -> {75,1,0},{75,1,1}; evt_valid 2 clk after first completing rx_valid.
REQ-037 Five make codes 0x15,0x1D,0x24,0x2D,0x2C, no pops, depth 4 -> count=4, overflow=1, head 0x15, fifth dropped; push+pop at full keeps count=4.
REQ-038 0xE0 then idle PREFIX_TIMEOUT cycles, then 0x1C -> proto_err=1, event {1C,0,0}; err_clear -> proto_err=0.
REQ-039 0xE0,0xF0,0xE0 -> proto_err=1, no event; 0xFF in IDLE -> proto_err, no event.
REQ-040 reset asserted after 0xF0 with 2 queued events -> count=0, all outputs 0; next 0x1C yields {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code controller.
// Holds the scan-code constants, the prefix FSM state encoding, the 10-bit
// event record layout and small byte classification helpers.
package ps2_pkg;

    localparam logic [7:0] ScPrefixExt = 8'hE0;  // extended-key prefix
    localparam logic [7:0] ScPrefixBrk = 8'hF0;  // key-release prefix
    localparam logic [7:0] ScErr00     = 8'h00;  // keyboard buffer overrun / error
    localparam logic [7:0] ScErrFf     = 8'hFF;  // keyboard error

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExt    = 2'd1,
        StBrk    = 2'd2,
        StExtBrk = 2'd3
    } ps2_state_e;

    // Event record: {ext, brk, code} = 10 bits.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int unsigned EvtWidth = $bits(ps2_evt_t);

    function automatic logic is_err_code(input logic [7:0] b);
        return (b == ScErr00) || (b == ScErrFf);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == ScPrefixExt) || (b == ScPrefixBrk);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write request and data
//   pop_i             consume head entry; ignored when empty
//   data_o            head entry, zero when empty
//   valid_o           FIFO non-empty
//   count_o           occupancy, 0..Depth
//   drop_o            push refused because full with no concurrent pop
module ps2_event_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [4:0]       count_o,
    output logic             drop_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == 5'(Depth));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointer overflow wraps modulo Depth.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scan-code controller: folds E0/F0 prefix bytes into 10-bit key events,
// queues them in an FWFT FIFO and raises a level interrupt while non-empty.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   rx_valid, rx_data        checked PS/2 byte, one-cycle strobe
//   evt_pop                  consume head event
//   irq_en                   interrupt enable
//   err_clear                clear sticky overflow / proto_err
//   evt_valid, evt_code,
//   evt_ext, evt_break       head event (zero when empty)
//   evt_count                FIFO occupancy
//   irq                      evt_valid & irq_en
//   overflow, proto_err      sticky error flags
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PREFIX_TIMEOUT = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       evt_pop,
    input  logic       irq_en,
    input  logic       err_clear,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [4:0] evt_count,
    output logic       irq,
    output logic       overflow,
    output logic       proto_err
);

    localparam int unsigned TmoW = $clog2(PREFIX_TIMEOUT + 1);

    ps2_state_e      state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_expired;

    logic            push_q, push_d;
    ps2_evt_t        push_evt_q, push_evt_d;
    logic            err_set;

    logic            proto_err_q, overflow_q;
    logic            fifo_drop;
    ps2_evt_t        head;

    assign tmo_expired = (state_q != StIdle) && (tmo_q == TmoW'(PREFIX_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; a received byte takes priority over timeout.
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == ScPrefixExt)      state_d = StExt;
                    else if (rx_data == ScPrefixBrk) state_d = StBrk;
                end
                StExt: begin
                    if (rx_data == ScPrefixBrk)      state_d = StExtBrk;
                    else if (rx_data == ScPrefixExt) state_d = StExt;
                    else                             state_d = StIdle;
                end
                StBrk: begin
                    if (rx_data == ScPrefixBrk)      state_d = StBrk;
                    else if (rx_data == ScPrefixExt) state_d = StExt;
                    else                             state_d = StIdle;
                end
                StExtBrk: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end else if (tmo_expired) begin
            state_d = StIdle;
        end
    end

    // Outputs: event push request and protocol-error strobe.
    always_comb begin
        push_d          = 1'b0;
        push_evt_d      = '0;
        push_evt_d.code = rx_data;
        err_set         = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (is_err_code(rx_data)) err_set = 1'b1;
                    else if (!is_prefix(rx_data)) push_d = 1'b1;
                end
                StExt: begin
                    push_evt_d.ext = 1'b1;
                    if (is_err_code(rx_data)) err_set = 1'b1;
                    else if (!is_prefix(rx_data)) push_d = 1'b1;
                end
                StBrk: begin
                    push_evt_d.brk = 1'b1;
                    // E0 after F0 is out of order but still starts an extended code.
                    if (is_err_code(rx_data) || rx_data == ScPrefixExt) err_set = 1'b1;
                    else if (rx_data != ScPrefixBrk) push_d = 1'b1;
                end
                StExtBrk: begin
                    push_evt_d.ext = 1'b1;
                    push_evt_d.brk = 1'b1;
                    if (is_err_code(rx_data) || is_prefix(rx_data)) err_set = 1'b1;
                    else push_d = 1'b1;
                end
                default: err_set = 1'b0;
            endcase
        end else if (tmo_expired) begin
            err_set = 1'b1;
        end
    end

    // Prefix timeout counter runs only while a prefix is pending.
    always_comb begin
        if (rx_valid || state_q == StIdle || tmo_expired) tmo_d = '0;
        else                                               tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_evt_q  <= '0;
            proto_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_evt_q  <= push_evt_d;
            // Set wins over a coincident clear.
            proto_err_q <= err_set || (proto_err_q && !err_clear);
            overflow_q  <= fifo_drop || (overflow_q && !err_clear);
        end
    end

    ps2_event_fifo #(
        .Width (EvtWidth),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_q),
        .data_i  (push_evt_q),
        .pop_i   (evt_pop),
        .data_o  (head),
        .valid_o (evt_valid),
        .count_o (evt_count),
        .drop_o  (fifo_drop)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign irq       = evt_valid && irq_en;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_scancode_ctrl;

    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 32;

    logic       clk = 1'b0;
    logic       reset, rx_valid, evt_pop, irq_en, err_clear;
    logic [7:0] rx_data;
    logic       evt_valid, evt_ext, evt_break, irq, overflow, proto_err;
    logic [7:0] evt_code;
    logic [4:0] evt_count;

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(
        .FIFO_DEPTH     (Depth),
        .PREFIX_TIMEOUT (Tmo)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .evt_pop   (evt_pop),
        .irq_en    (irq_en),
        .err_clear (err_clear),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_count (evt_count),
        .irq       (irq),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    typedef struct {
        logic [7:0] b;
        bit         push;
        bit         ext;
        bit         brk;
        bit         err;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];  // {ext, brk, code}
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] b, input bit push, input bit ext,
                                input bit brk, input bit err);
        vec_t v;
        v.b = b; v.push = push; v.ext = ext; v.brk = brk; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Compare head against scoreboard and pop until both are empty (bounded).
    task automatic drain();
        logic [9:0] e;
        for (int i = 0; i < 2 * Depth + 2; i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            chk("head_valid", 32'(evt_valid), 32'd1);
            chk("head_event", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, e});
            @(negedge clk);
            evt_pop = 1'b1;
            @(negedge clk);
            evt_pop = 1'b0;
        end
        chk("drained_queue", 32'(exp_q.size()), 32'd0);
        chk("drained_valid", 32'(evt_valid), 32'd0);
        chk("drained_count", 32'(evt_count), 32'd0);
        chk("empty_fields", {29'd0, evt_ext, evt_break, |evt_code}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        evt_pop = 1'b0; irq_en = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_fields", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);
        chk("rst_flags", {29'd0, irq, overflow, proto_err}, 32'd0);

        // Prefix decode table: proto_err cleared before every byte.
        add(8'h1C, 1, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0); add(8'h1C, 1, 0, 1, 0);
        add(8'hE0, 0, 0, 0, 0); add(8'h75, 1, 1, 0, 0);
        add(8'hE0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'h75, 1, 1, 1, 0);
        add(8'hE0, 0, 0, 0, 0); add(8'hE0, 0, 0, 0, 0); add(8'h6B, 1, 1, 0, 0);
        add(8'hF0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'h6B, 1, 0, 1, 0);
        add(8'hF0, 0, 0, 0, 0); add(8'hE0, 0, 0, 0, 1); add(8'h74, 1, 1, 0, 0);
        add(8'hE0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'hE0, 0, 0, 0, 1);
        add(8'h1C, 1, 0, 0, 0);
        add(8'hFF, 0, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1);
        add(8'hE0, 0, 0, 0, 0); add(8'h00, 0, 0, 0, 1); add(8'h1C, 1, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0); add(8'hFF, 0, 0, 0, 1); add(8'h1C, 1, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'h00, 0, 0, 0, 1);
        add(8'hE0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 1);
        add(8'h5A, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            pulse_clear();
            chk("err_cleared", 32'(proto_err), 32'd0);
            send_byte(vecs[i].b);
            chk("latency_1clk", 32'(evt_valid), 32'd0);
            chk("vec_proto_err", 32'(proto_err), 32'(vecs[i].err));
            @(negedge clk);
            if (vecs[i].push) exp_q.push_back({vecs[i].ext, vecs[i].brk, vecs[i].b});
            drain();
        end
        pulse_clear();

        // Two queued events with interrupt enabled.
        irq_en = 1'b1;
        send_byte(8'h1C);
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'hF0);
        send_byte(8'h1C);
        exp_q.push_back({2'b01, 8'h1C});
        @(negedge clk);
        chk("irq_count", 32'(evt_count), 32'd2);
        chk("irq_high", 32'(irq), 32'd1);
        drain();
        chk("irq_low", 32'(irq), 32'd0);

        // Pop on empty is ignored.
        @(negedge clk); evt_pop = 1'b1;
        @(negedge clk); evt_pop = 1'b0;
        chk("pop_empty_count", 32'(evt_count), 32'd0);

        // Overflow: fifth event dropped, queued ones intact.
        send_byte(8'h15); exp_q.push_back({2'b00, 8'h15});
        send_byte(8'h1D); exp_q.push_back({2'b00, 8'h1D});
        send_byte(8'h24); exp_q.push_back({2'b00, 8'h24});
        send_byte(8'h2D); exp_q.push_back({2'b00, 8'h2D});
        send_byte(8'h2C);
        @(negedge clk);
        @(negedge clk);
        chk("full_count", 32'(evt_count), 32'd4);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("full_head", 32'(evt_code), 32'h15);
        // Push coincident with pop at full.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h1B;
        @(negedge clk); rx_valid = 1'b0; evt_pop = 1'b1;
        @(negedge clk); evt_pop = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 8'h1B});
        chk("pushpop_full_count", 32'(evt_count), 32'd4);
        chk("pushpop_full_head", 32'(evt_code), 32'h1D);
        drain();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        pulse_clear();
        chk("overflow_cleared", 32'(overflow), 32'd0);

        // Error coincident with clear: set wins.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'hFF; err_clear = 1'b1;
        @(negedge clk); rx_valid = 1'b0; err_clear = 1'b0;
        chk("set_wins", 32'(proto_err), 32'd1);
        pulse_clear();

        // Prefix just inside the timeout window still completes.
        send_byte(8'hE0);
        repeat (Tmo - 2) @(negedge clk);
        chk("no_timeout_yet", 32'(proto_err), 32'd0);
        send_byte(8'h1C);
        exp_q.push_back({2'b10, 8'h1C});
        @(negedge clk);
        drain();

        // Prefix expires.
        send_byte(8'hE0);
        repeat (Tmo) @(negedge clk);
        chk("timeout_err", 32'(proto_err), 32'd1);
        send_byte(8'h1C);
        exp_q.push_back({2'b00, 8'h1C});
        @(negedge clk);
        drain();
        pulse_clear();
        chk("timeout_cleared", 32'(proto_err), 32'd0);

        // Reset mid-sequence with queued events and a pending prefix.
        send_byte(8'hFF);
        send_byte(8'h1C);
        send_byte(8'h2D);
        send_byte(8'hF0);
        @(negedge clk);
        chk("pre_reset_count", 32'(evt_count), 32'd2);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h1C;
        @(negedge clk); rx_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_count", 32'(evt_count), 32'd0);
        chk("mid_rst_outs", {20'd0, evt_valid, evt_ext, evt_break, irq, evt_code},
            32'd0);
        chk("mid_rst_flags", {30'd0, overflow, proto_err}, 32'd0);
        @(negedge clk);
        chk("rx_in_reset_ignored", 32'(evt_count), 32'd0);
        send_byte(8'h1C);
        exp_q.push_back({2'b00, 8'h1C});
        @(negedge clk);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
